serial_pad_receiver: RTL and testbench
======================================

# serial_pad_receiver

Parametrised multi-controller serial gamepad receiver for the TinyTapeStation input path. Drives a shared latch/clock pair to up to `NUM_PADS` shift-register controllers (NES at 8 bits, SNES at 16 bits). It samples one data line per pad and publishes debounced, active-high button vectors once per frame. It adds per-pad presence detection, press-edge pulses and continuous or gated polling, and supersedes the fixed single-pad NES receiver.

## Interface
- `NUM_PADS`, 2: number of controllers; legal range 1–4.
- `NUM_BITS`, 8: bits shifted per pad per frame (8 = NES, 16 = SNES); legal range 1–32.
- `LATCH_CYCLES`, 600: cycles the latch is held high (12 µs at 50 MHz).
- `HALF_CYCLES`, 300: cycles per `pad_clk` half-period (6 µs at 50 MHz); minimum 2.
- `GAP_CYCLES`, 1000: idle cycles between frames; 0 is legal.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: polling enable; sampled only in IDLE and GAP.
- `data` in `NUM_PADS`: serial data per pad, active-low (0 = pressed); bit p belongs to pad p.
- `latch` out 1: shared controller latch, registered.
- `pad_clk` out 1: shared controller shift clock, registered.
- `buttons` out `NUM_PADS*NUM_BITS`: pressed = 1; pad p occupies `[p*NUM_BITS +: NUM_BITS]`; bit 0 is the first bit shifted (A on NES, B on SNES).
- `pressed` out `NUM_PADS*NUM_BITS`: one-cycle pulse per button on a 0→1 transition of `buttons`.
- `present` out `NUM_PADS`: 1 = pad answered in the last frame.
- `frame_valid` out 1: one-cycle pulse when `buttons`, `pressed` and `present` update.
- `busy` out 1: high in LATCH, SETTLE, SHIFT_HI, SHIFT_LO.

## Operation
- States: IDLE → LATCH → SETTLE → (SHIFT_HI → SHIFT_LO) × (`NUM_BITS`−1) → DONE → GAP → LATCH or IDLE.
- **IDLE:** `latch`=0, `pad_clk`=0. Goes to LATCH the cycle after `enable`=1 is seen.
- **LATCH:** `latch`=1 for exactly `LATCH_CYCLES` cycles.
- **SETTLE:** `latch`=0, `pad_clk`=0 for `HALF_CYCLES` cycles. On the last cycle, bit 0 of every pad is captured into the shadow registers.
- **SHIFT_HI / SHIFT_LO:** `pad_clk`=1 for `HALF_CYCLES` cycles, then 0 for `HALF_CYCLES` cycles. Bit k (k = 1…`NUM_BITS`−1) is captured on the last cycle of the k-th SHIFT_HI. After the last bit's SHIFT_LO, go to DONE.
- Each captured bit is stored inverted: shadow = ~`data`.
- **DONE (1 cycle):**
  - For each pad, if every raw bit in the frame was 0 (floating or unplugged line): `present[p]`=0 and that pad's new vector is forced to all zeros. Otherwise `present[p]`=1 and the new vector is the shadow value.
  - `pressed` = new & ~old `buttons`.
  - `buttons` and `present` are loaded; `frame_valid`=1.
- **GAP:** `GAP_CYCLES` cycles (skipped when 0). At the end, go to LATCH if `enable`=1, else IDLE.
- `enable` deasserted mid-frame: the current frame completes normally, then the block stops at IDLE.
- `pressed` and `frame_valid` are 0 in every cycle other than DONE's registered output cycle.
- Bit counter width is `$clog2(NUM_BITS)`. Cycle counter width is `$clog2(max(LATCH_CYCLES, HALF_CYCLES, GAP_CYCLES)+1)`. The cycle counter clears on every state change.

## Timing
- Reset (`reset`=0, asynchronous): `latch`=0, `pad_clk`=0, `buttons`=0, `pressed`=0, `present`=0, `frame_valid`=0, `busy`=0, state IDLE, counters and shadows cleared. All of this takes effect immediately, including mid-frame.
- Reset release: the first `latch` rise occurs 2 cycles after `enable`=1 is sampled.
- Frame period (continuous polling) = `LATCH_CYCLES` + `HALF_CYCLES` + 2·`HALF_CYCLES`·(`NUM_BITS`−1) + 1 + `GAP_CYCLES`.
  - With defaults: 600 + 300 + 4200 + 1 + 1000 = 6101 cycles.
- `frame_valid` is asserted in the cycle after the final SHIFT_LO cycle. `buttons` is valid in that same cycle and holds until the next DONE.
- All outputs are registered; there are no combinational paths from `data` or `enable` to any output.

## Test plan
- **Reset mid-frame:** assert `reset`=0 during SHIFT_HI of bit 3. Required: `latch`/`pad_clk`/`buttons`/`present`=0 in the same cycle; after release with `enable`=1, a fresh LATCH of exactly 600 cycles.
- **NES pattern:** defaults, pad0 model returns pressed = 8'b1000_0101, pad1 returns 8'h00 pressed (all data=1). Required: `buttons`=16'h0085, `present`=2'b11, one `frame_valid` pulse, exactly 7 `pad_clk` high pulses of 300 cycles each.
- **Press edges:** frame N pad0 = 8'h01, frame N+1 = 8'h03. Required: `pressed`[7:0]=8'h01 at frame N, 8'h02 at frame N+1, and 0 at frame N+2 if the pattern is unchanged.
- **Unplugged pad:** pad1 data held at 0. Required: `present`=2'b01 and `buttons`[15:8]=0 while pad0 decodes normally.
- **SNES configuration:** `NUM_BITS`=16, `NUM_PADS`=1, `GAP_CYCLES`=0. Pad returns 16'hA5F0 pressed. Required: `buttons`=16'hA5F0, frame period 600 + 300 + 9000 + 1 = 9901 cycles.
- **Enable gating:** drop `enable` during LATCH. Required: that frame completes with `frame_valid` pulsing once, then IDLE with `latch` remaining 0.

Source files
------------

// File: rtl/serial_pad_receiver.sv
// rtl/serial_pad_receiver.sv - multi-pad NES/SNES serial gamepad receiver
// Ports:
//   clk, reset (async, active-low), enable (polling gate, sampled in IDLE/GAP)
//   data[NUM_PADS]        serial line per pad, 0 = pressed
//   latch, pad_clk        shared controller strobe and shift clock
//   buttons, pressed      per-pad active-high vectors and press-edge pulses
//   present               pad answered in the last frame
//   frame_valid, busy     frame update pulse, poll in progress
module serial_pad_receiver #(
    parameter int NUM_PADS     = 2,
    parameter int NUM_BITS     = 8,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int GAP_CYCLES   = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          data,
    output logic                         latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS-1:0]          present,
    output logic                         frame_valid,
    output logic                         busy
);

    localparam int MAX_LH  = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int MAX_ALL = (MAX_LH > GAP_CYCLES) ? MAX_LH : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam int BW      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [BW-1:0] LAST_BIT   = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETTLE,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_DONE,
        S_GAP
    } state_t;

    state_t                             state;
    state_t                             state_d;
    logic [CW-1:0]                      cnt;
    logic [BW-1:0]                      bit_cnt;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  shadow;

    logic                               cap_en;
    logic [BW-1:0]                      cap_idx;
    logic [NUM_PADS*NUM_BITS-1:0]       new_btn;
    logic [NUM_PADS-1:0]                new_present;

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (enable) state_d = S_LATCH;
            S_LATCH:    if (cnt == LATCH_LAST) state_d = S_SETTLE;
            S_SETTLE:   if (cnt == HALF_LAST) state_d = (NUM_BITS == 1) ? S_DONE : S_SHIFT_HI;
            S_SHIFT_HI: if (cnt == HALF_LAST) state_d = S_SHIFT_LO;
            S_SHIFT_LO: if (cnt == HALF_LAST) state_d = (bit_cnt == LAST_BIT) ? S_DONE : S_SHIFT_HI;
            S_DONE: begin
                if (GAP_CYCLES == 0) state_d = enable ? S_LATCH : S_IDLE;
                else                 state_d = S_GAP;
            end
            S_GAP:      if (cnt == GAP_LAST) state_d = enable ? S_LATCH : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bit 0 is on the line once latch drops; bit k appears after the k-th rising pad_clk
    // and is sampled at the end of that high phase.
    always_comb begin
        cap_en  = ((state == S_SETTLE) || (state == S_SHIFT_HI)) && (cnt == HALF_LAST);
        cap_idx = (state == S_SHIFT_HI) ? bit_cnt + BW'(1) : '0;
    end

    // A line that read 0 for every bit is floating/unplugged; shadow stores inverted data,
    // so that case shows up as an all-ones shadow.
    always_comb begin
        new_btn     = '0;
        new_present = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            new_present[p]                  = ~&shadow[p];
            new_btn[p*NUM_BITS +: NUM_BITS] = new_present[p] ? shadow[p] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_d;
            cnt   <= ((state_d != state) || (state == S_IDLE)) ? '0 : cnt + CW'(1);
            if (state == S_SETTLE)
                bit_cnt <= '0;
            else if ((state == S_SHIFT_HI) && cap_en)
                bit_cnt <= cap_idx;
        end
    end

    // Outputs are decoded from the current state and registered, so every output
    // lags the state register by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow      <= '0;
            latch       <= 1'b0;
            pad_clk     <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            buttons     <= '0;
            pressed     <= '0;
            present     <= '0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (cap_en) shadow[p][cap_idx] <= ~data[p];
            end
            latch       <= (state == S_LATCH);
            pad_clk     <= (state == S_SHIFT_HI);
            busy        <= (state == S_LATCH) || (state == S_SETTLE) ||
                           (state == S_SHIFT_HI) || (state == S_SHIFT_LO);
            frame_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                buttons <= new_btn;
                present <= new_present;
                pressed <= new_btn & ~buttons;
            end else begin
                pressed <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_pad_receiver.sv
// tb/tb_serial_pad_receiver.sv - self-checking bench for serial_pad_receiver
module tb_serial_pad_receiver;

    localparam int NP = 2;
    localparam int NB = 8;
    localparam int HC = 300;

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic        u1;
        logic [15:0] btn;
        logic [1:0]  pres;
        logic [15:0] prs;
    } vec_t;

    typedef struct {
        logic [15:0] btn;
        logic [1:0]  pres;
        logic [15:0] prs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, enable;
    logic [NP-1:0]    data;
    logic             latch, pad_clk, frame_valid, busy;
    logic [NP*NB-1:0] buttons, pressed;
    logic [NP-1:0]    present;

    logic             rst_s, en_s;
    logic [0:0]       data_s;
    logic             latch_s, pad_clk_s, fv_s, busy_s;
    logic [15:0]      buttons_s, pressed_s;
    logic [0:0]       present_s;

    serial_pad_receiver u_nes (
        .clk(clk), .reset(reset), .enable(enable), .data(data),
        .latch(latch), .pad_clk(pad_clk), .buttons(buttons), .pressed(pressed),
        .present(present), .frame_valid(frame_valid), .busy(busy)
    );

    serial_pad_receiver #(.NUM_PADS(1), .NUM_BITS(16), .GAP_CYCLES(0)) u_snes (
        .clk(clk), .reset(rst_s), .enable(en_s), .data(data_s),
        .latch(latch_s), .pad_clk(pad_clk_s), .buttons(buttons_s), .pressed(pressed_s),
        .present(present_s), .frame_valid(fv_s), .busy(busy_s)
    );

    // Controller models: shift register reloaded by latch, advanced by pad_clk rising.
    logic [7:0]  pat [NP];
    logic [NP-1:0] unplug = '0;
    logic [3:0]  nes_idx = '0;
    logic        nes_pc_q = 1'b0;
    logic [15:0] pat_s = 16'hA5F0;
    logic [4:0]  snes_idx = '0;
    logic        snes_pc_q = 1'b0;

    always @(negedge clk) begin
        if (latch) nes_idx = '0;
        else if (pad_clk && !nes_pc_q && nes_idx < 4'd8) nes_idx = nes_idx + 4'd1;
        nes_pc_q = pad_clk;
        if (latch_s) snes_idx = '0;
        else if (pad_clk_s && !snes_pc_q && snes_idx < 5'd16) snes_idx = snes_idx + 5'd1;
        snes_pc_q = pad_clk_s;
    end

    always_comb begin
        data = '1;
        for (int p = 0; p < NP; p++)
            data[p] = unplug[p] ? 1'b0 : ((nes_idx < 4'd8) ? ~pat[p][nes_idx[2:0]] : 1'b1);
        data_s[0] = (snes_idx < 5'd16) ? ~pat_s[snes_idx[3:0]] : 1'b1;
    end

    // pad_clk high-pulse monitor, cleared at each latch
    int pulses = 0, hi_len = 0, bad_w = 0;
    always @(negedge clk) begin
        if (latch) begin
            pulses = 0; hi_len = 0; bad_w = 0;
        end else if (pad_clk) begin
            hi_len = hi_len + 1;
        end else if (hi_len > 0) begin
            pulses = pulses + 1;
            if (hi_len != HC) bad_w = bad_w + 1;
            hi_len = 0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // which: 0 = NES frame_valid, 1 = SNES frame_valid, 2 = NES latch high
    task automatic wait_sig(input int which, input int limit, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && frame_valid) || (which == 1 && fv_s) || (which == 2 && latch)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(name, 64'(ok), 64'd1);
    endtask

    task automatic compare_frame(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_buttons"}, 64'(buttons), 64'(e.btn));
            check({tag, "_present"}, 64'(present), 64'(e.pres));
            check({tag, "_pressed"}, 64'(pressed), 64'(e.prs));
        end
    endtask

    vec_t vecs [6];

    initial begin
        int t_prev, t_now, n_fv, n_lat, width, rises;
        logic pc_prev;

        vecs[0] = '{8'h85, 8'h00, 1'b0, 16'h0085, 2'b11, 16'h0085};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 16'h0000, 2'b01, 16'h0000};
        vecs[2] = '{8'h01, 8'h00, 1'b0, 16'h0001, 2'b11, 16'h0001};
        vecs[3] = '{8'h03, 8'h00, 1'b0, 16'h0003, 2'b11, 16'h0002};
        vecs[4] = '{8'h03, 8'h00, 1'b0, 16'h0003, 2'b11, 16'h0000};
        vecs[5] = '{8'h00, 8'h81, 1'b0, 16'h8100, 2'b11, 16'h8100};

        reset = 1'b0; enable = 1'b0; rst_s = 1'b0; en_s = 1'b0;
        pat[0] = 8'h00; pat[1] = 8'h00;
        t_prev = 0;
        repeat (3) @(negedge clk);
        check("rst_latch", 64'(latch), 64'd0);
        check("rst_pad_clk", 64'(pad_clk), 64'd0);
        check("rst_buttons", 64'(buttons), 64'd0);
        check("rst_present", 64'(present), 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1; rst_s = 1'b1;
        @(negedge clk);

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    pat[0] = vecs[i].p0; pat[1] = vecs[i].p1; unplug[1] = vecs[i].u1;
                    sb.push_back('{vecs[i].btn, vecs[i].pres, vecs[i].prs});
                    enable = 1'b1;
                    wait_sig(0, 8000, $sformatf("v%0d_fv_timeout", i));
                    t_now = cyc;
                    compare_frame($sformatf("v%0d", i));
                    check($sformatf("v%0d_clk_pulses", i), 64'(pulses), 64'd7);
                    check($sformatf("v%0d_clk_width_bad", i), 64'(bad_w), 64'd0);
                    if (i > 0) check($sformatf("v%0d_period", i), 64'(t_now - t_prev), 64'd6101);
                    t_prev = t_now;
                    @(negedge clk);
                    check($sformatf("v%0d_pressed_clear", i), 64'(pressed), 64'd0);
                    check($sformatf("v%0d_fv_pulse", i), 64'(frame_valid), 64'd0);
                end

                // enable dropped during LATCH: frame completes, then stays idle
                wait_sig(2, 8000, "gate_latch_timeout");
                enable = 1'b0;
                sb.push_back('{16'h8100, 2'b11, 16'h0000});
                wait_sig(0, 8000, "gate_fv_timeout");
                compare_frame("gate");
                n_fv = 0; n_lat = 0;
                repeat (8000) begin
                    @(negedge clk);
                    if (frame_valid) n_fv++;
                    if (latch) n_lat++;
                end
                check("gate_extra_fv", 64'(n_fv), 64'd0);
                check("gate_latch_high", 64'(n_lat), 64'd0);
                check("gate_busy", 64'(busy), 64'd0);

                // latch latency from enable, then asynchronous reset mid-shift
                enable = 1'b1;
                @(negedge clk);
                check("lat_cycle1", 64'(latch), 64'd0);
                @(negedge clk);
                check("lat_cycle2", 64'(latch), 64'd1);
                rises = 0; pc_prev = 1'b0;
                for (int i = 0; i < 6000 && rises < 3; i++) begin
                    @(negedge clk);
                    if (pad_clk && !pc_prev) rises++;
                    pc_prev = pad_clk;
                end
                check("rst_mid_reach_bit3", 64'(rises), 64'd3);
                repeat (100) @(negedge clk);
                reset = 1'b0;
                #1;
                check("rst_mid_latch", 64'(latch), 64'd0);
                check("rst_mid_pad_clk", 64'(pad_clk), 64'd0);
                check("rst_mid_buttons", 64'(buttons), 64'd0);
                check("rst_mid_present", 64'(present), 64'd0);
                check("rst_mid_busy", 64'(busy), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                wait_sig(2, 100, "rst_relatch_timeout");
                width = 0;
                while (latch && width < 2000) begin
                    width++;
                    @(negedge clk);
                end
                check("rst_relatch_width", 64'(width), 64'd600);
            end
            begin
                int s1;
                en_s = 1'b1;
                wait_sig(1, 25000, "snes_fv1_timeout");
                s1 = cyc;
                check("snes_buttons", 64'(buttons_s), 64'h0000_0000_0000_A5F0);
                check("snes_present", 64'(present_s), 64'd1);
                check("snes_pressed", 64'(pressed_s), 64'h0000_0000_0000_A5F0);
                wait_sig(1, 25000, "snes_fv2_timeout");
                check("snes_period", 64'(cyc - s1), 64'd9901);
                check("snes_pressed_steady", 64'(pressed_s), 64'd0);
                en_s = 1'b0;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
